// File: rtl/sort_pkg.sv
// Shared types and defaults for the sorter front end (state encoding, pad value, default sizes).
package sort_pkg;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int unsigned N_DEF     = 6;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W     = $clog2(N_DEF + 1);
  localparam int unsigned PAD_MAX_W = 64;

  // All-ones word of the requested width, right-aligned in a PAD_MAX_W container.
  function automatic logic [PAD_MAX_W-1:0] pad_value(input int unsigned width);
    logic [PAD_MAX_W-1:0] v;
    v = '1;
    return v >> (PAD_MAX_W - width);
  endfunction

endpackage

// File: rtl/sort_frame_loader.sv
// Assembles a valid/ready word stream into padded N-word frames and hands each to the sorter.
// Optional abort on a missing sort_done is enabled by defining SORT_TIMEOUT_EN.
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
`ifdef SORT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 64
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_in_valid,
  input  logic [WIDTH-1:0]             i_in_data,
  input  logic                         i_in_last,
  output logic                         o_in_ready,
  output logic [WIDTH-1:0]             o_frame_data [N],
  output logic [$clog2(N+1)-1:0]       o_frame_len,
  output logic                         o_sort_start,
  input  logic                         i_sort_done,
  output logic                         o_busy,
  output logic                         o_timeout_err
);

  localparam int unsigned LEN_W = $clog2(N + 1);
  localparam logic [WIDTH-1:0] PAD = WIDTH'(pad_value(WIDTH));

  state_t           r_state;
  state_t           w_next_state;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [WIDTH-1:0] r_frame [N];
  logic             r_start;
  logic             r_busy;
  logic             w_xfer;
  logic             w_close;
  logic             w_timeout;

`ifdef SORT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;

  assign w_timeout = (r_state == WAIT_DONE) && !i_sort_done &&
                     (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Watchdog: counts cycles spent in WAIT_DONE, restarted by LAUNCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == LAUNCH) begin
        r_to_cnt <= '0;
      end else if (r_state == WAIT_DONE) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_next_state = r_state;
    w_xfer       = 1'b0;
    w_close      = 1'b0;
    case (r_state)
      FILL: begin
        w_xfer  = i_in_valid;
        w_close = i_in_valid && (i_in_last || (r_cnt == LEN_W'(N - 1)));
        if (w_close) begin
          w_next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        w_next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_sort_done || w_timeout) begin
          w_next_state = FILL;
        end
      end
      default: begin
        w_next_state = FILL;
      end
    endcase
  end

  // Frame storage, write index, length and sorter strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_frame[i] <= '0;
      end
    end else begin
      // LAUNCH is only entered from FILL, so this is a single-cycle pulse.
      r_start <= (w_next_state == LAUNCH);
      r_busy  <= (w_next_state != FILL);
      if (w_xfer) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end else if ((r_state == WAIT_DONE) && (w_next_state == FILL)) begin
        r_cnt <= '0;
      end
      if (w_close) begin
        r_len <= r_cnt + LEN_W'(1);
      end
      // Pad slots beyond the closing beat with all ones so they sort to the tail.
      for (int i = 0; i < N; i++) begin
        if (w_xfer && (LEN_W'(i) == r_cnt)) begin
          r_frame[i] <= i_in_data;
        end else if (w_close && (LEN_W'(i) > r_cnt)) begin
          r_frame[i] <= PAD;
        end
      end
    end
  end

  assign o_in_ready   = (r_state == FILL);
  assign o_frame_data = r_frame;
  assign o_frame_len  = r_len;
  assign o_sort_start = r_start;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Self-checking bench for sort_frame_loader; timeout scenario runs only with SORT_TIMEOUT_EN.
module tb_sort_frame_loader;

  localparam int N = 6;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] frame_data [N];
  logic [2:0]   frame_len;
  logic         sort_start;
  logic         sort_done;
  logic         busy;
  logic         timeout_err;

  int total = 0;
  int bad   = 0;

  sort_frame_loader #(.N(N), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .i_in_last    (in_last),
    .o_in_ready   (in_ready),
    .o_frame_data (frame_data),
    .o_frame_len  (frame_len),
    .o_sort_start (sort_start),
    .i_sort_done  (sort_done),
    .o_busy       (busy),
    .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a frame is its words in order followed by all-ones padding.
  function automatic void model_frame(input logic [W-1:0] q[$], output logic [W-1:0] exp[N],
                                      output int len);
    len = (q.size() > N) ? N : q.size();
    for (int i = 0; i < N; i++) exp[i] = (i < len) ? q[i] : 8'hFF;
  endfunction

  task automatic drive_beats(input logic [W-1:0] q[$], input bit last_on_final);
    for (int i = 0; i < q.size(); i++) begin
      in_valid = 1'b1;
      in_data  = q[i];
      in_last  = last_on_final && (i == q.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_done();
    sort_done = 1'b1;
    tick();
    sort_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %0b want 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    total++; if (sort_start !== 1'b0) begin bad++; $display("FAIL reset_start got %0b want 0", sort_start); end
    total++; if (frame_len !== 3'd0) begin bad++; $display("FAIL reset_len got %0d want 0", frame_len); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err got %0b want 0", timeout_err); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (frame_data[i] !== 8'd0) begin bad++; $display("FAIL reset_frame[%0d] got %0d want 0", i, frame_data[i]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    logic [W-1:0] q[$];
    logic [W-1:0] exp [N];
    int len;
    q = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2};
    model_frame(q, exp, len);
    drive_beats(q, 1'b1);
    total++; if (sort_start !== 1'b1) begin bad++; $display("FAIL full_start got %0b want 1", sort_start); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy got %0b want 1", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %0b want 0", in_ready); end
    total++; if (frame_len !== 3'(len)) begin bad++; $display("FAIL full_len got %0d want %0d", frame_len, len); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (frame_data[i] !== exp[i]) begin bad++; $display("FAIL full_frame[%0d] got %0d want %0d", i, frame_data[i], exp[i]); end
    end
    tick();
    total++; if (sort_start !== 1'b0) begin bad++; $display("FAIL full_start_width got %0b want 0", sort_start); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_wait_busy got %0b want 1", busy); end
    // Stream keeps offering a word while the sort is in flight.
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0; in_last = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready got %0b want 0", in_ready); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (frame_data[i] !== exp[i]) begin bad++; $display("FAIL hold_frame[%0d] got %0d want %0d", i, frame_data[i], exp[i]); end
    end
    pulse_done();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL done_ready got %0b want 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_busy got %0b want 0", busy); end
    total++; if (frame_len !== 3'd6) begin bad++; $display("FAIL retained_len got %0d want 6", frame_len); end
  endtask

  task automatic test_short_frame();
    logic [W-1:0] q[$];
    logic [W-1:0] exp [N];
    int len;
    q = '{8'd5, 8'd4};
    model_frame(q, exp, len);
    drive_beats(q, 1'b1);
    total++; if (frame_len !== 3'(len)) begin bad++; $display("FAIL short_len got %0d want %0d", frame_len, len); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (frame_data[i] !== exp[i]) begin bad++; $display("FAIL short_frame[%0d] got %0d want %0d", i, frame_data[i], exp[i]); end
    end
    tick();
    pulse_done();
  endtask

  task automatic test_overlong();
    logic [W-1:0] all[$];
    logic [W-1:0] q[$];
    logic [W-1:0] exp [N];
    int len;
    for (int i = 0; i < 8; i++) all.push_back(W'($urandom_range(0, 254)));
    q = all[0:5];
    model_frame(q, exp, len);
    drive_beats(q, 1'b0);
    total++; if (sort_start !== 1'b1) begin bad++; $display("FAIL over_start got %0b want 1", sort_start); end
    total++; if (frame_len !== 3'd6) begin bad++; $display("FAIL over_len got %0d want 6", frame_len); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (frame_data[i] !== exp[i]) begin bad++; $display("FAIL over_frame[%0d] got %0d want %0d", i, frame_data[i], exp[i]); end
    end
    in_valid = 1'b1; in_data = all[6]; in_last = 1'b0;
    repeat (3) tick();
    total++; if (frame_data[0] !== exp[0]) begin bad++; $display("FAIL over_hold got %0d want %0d", frame_data[0], exp[0]); end
    pulse_done();
    tick();
    in_data = all[7]; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    q = all[6:7];
    model_frame(q, exp, len);
    total++; if (frame_len !== 3'(len)) begin bad++; $display("FAIL over2_len got %0d want %0d", frame_len, len); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (frame_data[i] !== exp[i]) begin bad++; $display("FAIL over2_frame[%0d] got %0d want %0d", i, frame_data[i], exp[i]); end
    end
    tick();
    pulse_done();
  endtask

  task automatic test_done_ignored();
    logic [W-1:0] q[$];
    pulse_done();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_done_ready got %0b want 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fill_done_busy got %0b want 0", busy); end
    total++; if (sort_start !== 1'b0) begin bad++; $display("FAIL fill_done_start got %0b want 0", sort_start); end
    q = '{8'd11, 8'd22, 8'd33};
    drive_beats(q, 1'b1);
    pulse_done();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL launch_done_busy got %0b want 1", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL launch_done_ready got %0b want 0", in_ready); end
    total++; if (frame_len !== 3'd3) begin bad++; $display("FAIL launch_done_len got %0d want 3", frame_len); end
    pulse_done();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL launch_done_release got %0b want 1", in_ready); end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] exp [N];
    int len;
    int k;
    for (int it = 0; it < 20; it++) begin
      q.delete();
      k = int'($urandom_range(1, N));
      for (int i = 0; i < k; i++) q.push_back(W'($urandom));
      model_frame(q, exp, len);
      drive_beats(q, (k < N) ? 1'b1 : 1'($urandom_range(0, 1)));
      total++; if (sort_start !== 1'b1) begin bad++; $display("FAIL rnd%0d_start got %0b want 1", it, sort_start); end
      total++; if (frame_len !== 3'(len)) begin bad++; $display("FAIL rnd%0d_len got %0d want %0d", it, frame_len, len); end
      for (int i = 0; i < N; i++) begin
        total++;
        if (frame_data[i] !== exp[i]) begin bad++; $display("FAIL rnd%0d_frame[%0d] got %0d want %0d", it, i, frame_data[i], exp[i]); end
      end
      in_valid = 1'($urandom_range(0, 1)); in_data = W'($urandom);
      repeat (1 + $urandom_range(0, 3)) tick();
      in_valid = 1'b0;
      total++; if (sort_start !== 1'b0) begin bad++; $display("FAIL rnd%0d_start_low got %0b want 0", it, sort_start); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rnd%0d_ready got %0b want 0", it, in_ready); end
      pulse_done();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rnd%0d_release got %0b want 1", it, in_ready); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q[$];
    q = '{8'd40, 8'd41, 8'd42};
    drive_beats(q, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++; if (frame_len !== 3'd0) begin bad++; $display("FAIL midrst_len got %0d want 0", frame_len); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got %0b want 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got %0b want 0", busy); end
    for (int i = 0; i < N; i++) begin
      total++;
      if (frame_data[i] !== 8'd0) begin bad++; $display("FAIL midrst_frame[%0d] got %0d want 0", i, frame_data[i]); end
    end
    tick();
    rst = 1'b0;
    tick();
    q = '{8'd77, 8'd66};
    drive_beats(q, 1'b1);
    total++; if (frame_len !== 3'd2) begin bad++; $display("FAIL postrst_len got %0d want 2", frame_len); end
    total++; if (frame_data[0] !== 8'd77) begin bad++; $display("FAIL postrst_slot0 got %0d want 77", frame_data[0]); end
    total++; if (frame_data[2] !== 8'hFF) begin bad++; $display("FAIL postrst_slot2 got %0d want 255", frame_data[2]); end
    tick();
    pulse_done();
  endtask

`ifdef SORT_TIMEOUT_EN
  task automatic test_timeout();
    logic [W-1:0] q[$];
    int n;
    q = '{8'd1, 8'd2, 8'd3};
    drive_beats(q, 1'b1);
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    // Closing edge leads to LAUNCH; WAIT_DONE is entered one edge later, then 64 edges elapse.
    total++; if (n !== 65) begin bad++; $display("FAIL timeout_delay got %0d want 65", n); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL timeout_ready got %0b want 1", in_ready); end
    tick();
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got %0b want 1", timeout_err); end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; sort_done = 1'b0;
    tick();
    test_reset();
    test_full_frame();
    test_short_frame();
    test_overlong();
    test_done_ignored();
    test_random();
    test_reset_mid();
`ifdef SORT_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_frame_loader.md
Name: sort_frame_loader

Overview:
Upstream feeder for the parallel N-element sorter FSM. Accepts a valid/ready word stream and assembles up to N words into a parallel frame, padding short frames. Issues a one-cycle start pulse to the sorter and holds the frame stable until the sorter's done pulse, then accepts the next frame. Sorter reads its input array combinationally across several states, so the frame must not change while a sort is in flight.

Parameters:
N, 6, words per frame; must match the sorter's N; N >= 2
WIDTH, 8, bits per word; must match the sorter's WIDTH
TIMEOUT, 64, cycles to wait for sort_done before abort (used only with SORT_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  stream word valid
in_data  in  WIDTH  stream word, unsigned
in_last  in  1  marks final word of a frame
in_ready  out  1  loader can accept a word
frame_data  out  WIDTH x N (unpacked [N])  assembled frame; connects to sorter data_in
frame_len  out  $clog2(N+1)  number of real (non-pad) words in current frame
sort_start  out  1  one-cycle start pulse to sorter
sort_done  in  1  sorter done pulse
busy  out  1  high from LAUNCH through WAIT_DONE
timeout_err  out  1  sticky abort flag (SORT_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, rst=1): state=FILL, write index cnt=0, frame_data all 0, frame_len=0, sort_start=0, busy=0, timeout_err=0.
- in_ready = (state==FILL); decoded from the state register only, no combinational path from in_valid.
- Handshake: a beat transfers when in_valid && in_ready at a rising clk edge. in_data and in_last are sampled only on a transfer.
- FILL:
  - Each transfer writes in_data to frame_data[cnt] and increments cnt.
  - Closing beat: a transfer with in_last=1, or a transfer at cnt==N-1 regardless of in_last.
  - On the closing beat, in the same edge:
    - frame_len = cnt+1.
    - Slots cnt+1..N-1 are written with the pad value (all ones), so padding sorts to the tail.
    - Next state = LAUNCH.
  - If cnt==N-1 and in_last=0, the frame is truncated at N; the next word begins a new frame.
- LAUNCH (exactly 1 cycle): sort_start=1, busy=1, next state = WAIT_DONE.
- WAIT_DONE: sort_start=0, busy=1, frame_data and frame_len held. On sort_done=1: cnt=0, next state = FILL.
- sort_start is registered. It is never high for two consecutive cycles and is low for at least one cycle between frames, which guarantees the sorter sees a fresh rising edge.
- Latency: closing beat at edge t; sort_start high during cycle t..t+1; in_ready returns the cycle after sort_done is sampled.
- sort_done while in FILL or LAUNCH: ignored.
- Reset mid-operation: any partial frame is discarded and the loader returns to FILL. The sorter shares rst.
- frame_len is retained after return to FILL, until the next closing beat.

Optional Feature:
SORT_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE. If it reaches TIMEOUT without sort_done, then timeout_err <= 1 (sticky until rst), cnt=0 and state goes to FILL.
- Undefined: no counter; WAIT_DONE waits indefinitely; timeout_err is tied 0.

Decomposition:
- Shared package sort_pkg:
  - state typedef {FILL, LAUNCH, WAIT_DONE}
  - default N/WIDTH localparams
  - function pad_value(WIDTH) returning all ones
  - CNT_W = $clog2(N+1)
- No sub-module needed. The optional timeout counter stays inline, guarded by the macro.

Test Plan:
- Full frame N=6, words 9,3,7,1,8,2 with in_last on the 6th -> frame_data={9,3,7,1,8,2}, frame_len=6, sort_start high exactly 1 cycle, in_ready=0 until sort_done; with sorter attached, data_sorted={1,2,3,7,8,9}.
- Short frame 5,4 with in_last on the 2nd -> frame_data={5,4,255,255,255,255}, frame_len=2.
- Overlong stream of 8 words, no in_last -> first frame closes at word 6; words 7 and 8 start the next frame only after sort_done.
- in_valid held high during WAIT_DONE -> no transfers, frame_data unchanged; sort_done in FILL is ignored with no state change.
- rst pulsed mid-FILL after 3 words -> all outputs return to reset values; the next frame starts at slot 0.
- SORT_TIMEOUT_EN, TIMEOUT=64, sort_done tied 0 -> timeout_err rises 64 cycles after entering WAIT_DONE; in_ready=1 on the next cycle.
